// File: rtl/dmem_responder.sv
// Word-organised data RAM behind valid/ready request and response channels.
// Serves byte/half/word loads and stores with a fixed access latency; one request in flight.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_signed_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o,
   output logic        busy_o
);

   // state  | meaning
   // S_IDLE | ready for a request, req_ready high
   // S_WAIT | request captured, counting down the access latency
   // S_RESP | access committed, response held until resp_ready
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] DEPTH_L  = 32'(DEPTH_WORDS);
   localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        wr_q, sgn_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q, wdata_q;
   logic        ready_q, valid_q, err_q, busy_q;
   logic [31:0] rdata_q;
   logic [31:0] mem_q [DEPTH_WORDS];

   logic        f_write, f_sgn;
   logic [1:0]  f_size;
   logic [31:0] f_addr, f_wdata;
   logic        accept, commit, acc_err;
   logic [AW-1:0] idx;
   logic [31:0] rd_word, shifted, load_data, resp_data, st_data;
   logic [15:0] half;
   logic [3:0]  be;

   // With LATENCY=1 the access commits on the accept edge, so the live request fields are used.
   always_comb begin
      f_write = wr_q;
      f_sgn   = sgn_q;
      f_size  = size_q;
      f_addr  = addr_q;
      f_wdata = wdata_q;
      if (state_q == S_IDLE) begin
         f_write = req_write_i;
         f_sgn   = req_signed_i;
         f_size  = req_size_i;
         f_addr  = req_addr_i;
         f_wdata = req_wdata_i;
      end
   end

   assign accept = (state_q == S_IDLE) && req_valid_i;
   assign commit = ((state_q == S_WAIT) && (cnt_q == 4'd0)) || (accept && (LATENCY == 1));

   assign acc_err = (f_size == 2'b11)
                  | ((f_size == 2'b01) && f_addr[0])
                  | ((f_size == 2'b10) && (f_addr[1:0] != 2'b00))
                  | ({2'b00, f_addr[31:2]} >= DEPTH_L);

   assign idx     = f_addr[AW+1:2];
   assign rd_word = mem_q[idx];

   always_comb begin
      shifted   = rd_word >> {f_addr[1:0], 3'b000};
      half      = f_addr[1] ? rd_word[31:16] : rd_word[15:0];
      load_data = rd_word;
      case (f_size)
         2'b00:   load_data = f_sgn ? {{24{shifted[7]}}, shifted[7:0]} : {24'b0, shifted[7:0]};
         2'b01:   load_data = f_sgn ? {{16{half[15]}}, half} : {16'b0, half};
         default: load_data = rd_word;
      endcase
      resp_data = (acc_err || f_write) ? 32'd0 : load_data;
   end

   always_comb begin
      be      = 4'b1111;
      st_data = f_wdata;
      case (f_size)
         2'b00: begin
            be      = 4'b0001 << f_addr[1:0];
            st_data = {4{f_wdata[7:0]}};
         end
         2'b01: begin
            be      = f_addr[1] ? 4'b1100 : 4'b0011;
            st_data = {2{f_wdata[15:0]}};
         end
         default: begin
            be      = 4'b1111;
            st_data = f_wdata;
         end
      endcase
   end

   // RAM is never reset; a reset on the commit edge suppresses the write.
   always_ff @(posedge clk_i) begin
      if (!rst_i && commit && f_write && !acc_err) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_q[idx][8*b +: 8] <= st_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         sgn_q   <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid_i) begin
                  wr_q    <= req_write_i;
                  sgn_q   <= req_signed_i;
                  size_q  <= req_size_i;
                  addr_q  <= req_addr_i;
                  wdata_q <= req_wdata_i;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  if (LATENCY == 1) begin
                     state_q <= S_RESP;
                     valid_q <= 1'b1;
                     rdata_q <= resp_data;
                     err_q   <= acc_err;
                  end else begin
                     state_q <= S_WAIT;
                     cnt_q   <= CNT_INIT;
                  end
               end
            end
            S_WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q <= S_RESP;
                  valid_q <= 1'b1;
                  rdata_q <= resp_data;
                  err_q   <= acc_err;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_RESP: begin
               if (resp_ready_i) begin
                  state_q <= S_IDLE;
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                  rdata_q <= 32'd0;
                  err_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               valid_q <= 1'b0;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready_o  = ready_q;
   assign resp_valid_o = valid_q;
   assign resp_rdata_o = rdata_q;
   assign resp_err_o   = err_q;
   assign busy_o       = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: two instances (latency 2 and 4) share request fields;
// a forked monitor checks every response against a queue of hand-computed expectations.
module tb_dmem_responder;

   typedef struct {
      int          inst;
      logic [31:0] rd;
      logic        er;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req_valid = 2'b00;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b10;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_ready = 1'b1;
   logic [1:0]  rdy, rv, er, bz;
   logic [31:0] rd0, rd1;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t q[$];
   bit [1:0] seen = 2'b00;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_l2 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[0]), .req_ready_o(rdy[0]),
      .req_write_i(req_write), .req_size_i(req_size), .req_signed_i(req_signed),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .resp_valid_o(rv[0]),
      .resp_ready_i(resp_ready), .resp_rdata_o(rd0), .resp_err_o(er[0]), .busy_o(bz[0]));

   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_l4 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[1]), .req_ready_o(rdy[1]),
      .req_write_i(req_write), .req_size_i(req_size), .req_signed_i(req_signed),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .resp_valid_o(rv[1]),
      .resp_ready_i(resp_ready), .resp_rdata_o(rd1), .resp_err_o(er[1]), .busy_o(bz[1]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Drives one request into instance k; returns on the negedge after the accept edge.
   task automatic issue(input int k, input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd, input bit push,
                        input logic [31:0] exp_rd, input bit exp_er);
      int   n;
      exp_t e;
      @(negedge clk);
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      req_valid[k] = 1'b1;
      n = 0;
      while (!rdy[k] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!rdy[k]) begin
         req_valid[k] = 1'b0;
         chk("accept_timeout", 32'(rdy[k]), 32'd1);
         return;
      end
      @(negedge clk);
      req_valid[k] = 1'b0;
      if (push) begin
         e.inst = k;
         e.rd   = exp_rd;
         e.er   = exp_er;
         e.cyc  = cyc + ((k == 0) ? 1 : 3);
         q.push_back(e);
      end
   endtask

   task automatic wait_done(input int k);
      int n;
      n = 0;
      while ((q.size() != 0 || !rdy[k]) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0 || !rdy[k]) chk("drain_timeout", 32'(q.size()), 32'd0);
   endtask

   task automatic op(input int k, input bit wr, input logic [1:0] sz, input bit sg,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input bit exp_er);
      issue(k, wr, sz, sg, a, wd, 1'b1, exp_rd, exp_er);
      wait_done(k);
   endtask

   initial begin
      exp_t e;
      int   n;
      fork
         forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
               if (rv[k] && !seen[k]) begin
                  seen[k] = 1'b1;
                  if (q.size() == 0) begin
                     total++;
                     bad++;
                     $display("FAIL stray_resp inst=%0d actual=resp_valid required=idle", k);
                  end else begin
                     e = q.pop_front();
                     chk("resp_inst", 32'(k), 32'(e.inst));
                     chk("resp_rdata", (k == 0) ? rd0 : rd1, e.rd);
                     chk("resp_err", 32'(er[k]), 32'(e.er));
                     chk("resp_latency", 32'(cyc), 32'(e.cyc));
                  end
               end
               if (!rv[k]) seen[k] = 1'b0;
            end
         end
      join_none

      // reset values
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", 32'(rdy), 32'h3);
      chk("rst_valid", 32'(rv), 32'h0);
      chk("rst_busy", 32'(bz), 32'h0);

      // word store/load
      op(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
      op(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);

      // byte lanes and extension
      op(0, 1, 2'b00, 0, 32'h11, 32'h00000080, 32'h0, 0);
      op(0, 0, 2'b00, 1, 32'h11, 32'h0, 32'hFFFFFF80, 0);
      op(0, 0, 2'b00, 0, 32'h11, 32'h0, 32'h00000080, 0);
      op(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD80EF, 0);
      op(0, 0, 2'b01, 1, 32'h10, 32'h0, 32'hFFFF80EF, 0);

      // half store, misalignment and illegal size
      op(0, 1, 2'b01, 0, 32'h12, 32'h00001234, 32'h0, 0);
      op(0, 0, 2'b01, 0, 32'h12, 32'h0, 32'h00001234, 0);
      op(0, 0, 2'b01, 0, 32'h13, 32'h0, 32'h0, 1);
      op(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'h123480EF, 0);
      op(0, 1, 2'b10, 0, 32'h4002, 32'hFFFFFFFF, 32'h0, 1);
      op(0, 0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1);
      op(0, 1, 2'b11, 0, 32'h10, 32'hAAAAAAAA, 32'h0, 1);
      op(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'h123480EF, 0);

      // out-of-range must not alias word 0
      op(0, 1, 2'b10, 0, 32'h0, 32'hCAFEF00D, 32'h0, 0);
      op(0, 0, 2'b10, 0, 32'h1000, 32'h0, 32'h0, 1);
      op(0, 1, 2'b10, 0, 32'h1000, 32'h11111111, 32'h0, 1);
      op(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'hCAFEF00D, 0);

      // response held by back-pressure; stray request ignored
      resp_ready = 1'b0;
      issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 1'b1, 32'h123480EF, 0);
      n = 0;
      while (!rv[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("hold_reached", 32'(rv[0]), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 1) begin
            req_addr  = 32'h0;
            req_write = 1'b1;
            req_valid[0] = 1'b1;
         end
         if (i == 2) req_valid[0] = 1'b0;
         chk("hold_valid", 32'(rv[0]), 32'd1);
         chk("hold_rdata", rd0, 32'h123480EF);
         chk("hold_ready", 32'(rdy[0]), 32'd0);
         chk("hold_busy", 32'(bz[0]), 32'd1);
      end
      req_write  = 1'b0;
      resp_ready = 1'b1;
      wait_done(0);
      repeat (4) @(negedge clk);
      chk("no_extra_accept", 32'(bz[0]), 32'd0);
      op(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'hCAFEF00D, 0);

      // latency 4: reset during WAIT drops the store
      op(1, 1, 2'b10, 0, 32'h20, 32'h0, 32'h0, 0);
      op(1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h0, 0);
      issue(1, 1, 2'b10, 0, 32'h20, 32'h55, 1'b0, 32'h0, 0);
      chk("abort_in_wait", 32'(bz[1]), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_ready", 32'(rdy[1]), 32'd1);
      chk("abort_valid", 32'(rv[1]), 32'd0);
      chk("abort_busy", 32'(bz[1]), 32'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("abort_no_resp", 32'(rv[1]), 32'd0);
      end
      op(1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h0, 0);
      op(1, 1, 2'b01, 0, 32'h22, 32'h0000BEEF, 32'h0, 0);
      op(1, 0, 2'b01, 1, 32'h22, 32'h0, 32'hFFFFBEEF, 0);
      op(1, 0, 2'b10, 0, 32'h20, 32'h0, 32'hBEEF0000, 0);

      repeat (3) @(negedge clk);
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
